// File: rtl/fifo_bram_ctrl_pkg.sv
// fifo_bram_ctrl_pkg
//   Shared definitions for the BRAM-backed FWFT FIFO controller:
//   default geometry, pointer/level width and depth helpers, and the
//   output-stage state encoding.
package fifo_bram_ctrl_pkg;

  localparam int DEF_DATA = 8;
  localparam int DEF_ADDR = 6;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addr);
    return addr + 1;
  endfunction

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  localparam int DEF_PTR_W = ptr_width(DEF_ADDR);
  localparam int DEF_DEPTH = depth_of(DEF_ADDR);

  // Output stage: is a fetched head word currently on out_data?
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/bram_2psync_6_8_59fe624214af9b8daa183282288d5eb56b321f14.sv
// bram_2psync_6_8_59fe624214af9b8daa183282288d5eb56b321f14
//   Two-port synchronous BRAM. Each port can write on the rising edge and
//   reads through a registered address: rdata shows mem[addr] one cycle
//   after addr is presented.
//   Ports:
//     clk                       clock
//     a_we / a_addr / a_wdata   port a write enable, address, write data
//     a_rdata                   port a read data (registered address)
//     b_we / b_addr / b_wdata   port b write enable, address, write data
//     b_rdata                   port b read data (registered address)
module bram_2psync_6_8_59fe624214af9b8daa183282288d5eb56b321f14 #(
  parameter int DATA = 8,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_wdata,
  output logic [DATA-1:0] a_rdata,
  input  logic            b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_wdata,
  output logic [DATA-1:0] b_rdata
);

  logic [DATA-1:0] mem [2**ADDR];
  logic [ADDR-1:0] a_addr_q;
  logic [ADDR-1:0] b_addr_q;

  // NOTE: the array and address registers have no reset; a block RAM cannot
  // be cleared in one cycle, and the controller never reads a slot it has
  // not written since reset.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_addr_q <= a_addr;
    b_addr_q <= b_addr;
  end

  assign a_rdata = mem[a_addr_q];
  assign b_rdata = mem[b_addr_q];

endmodule

// File: rtl/fifo_bram_ctrl.sv
// fifo_bram_ctrl
//   First-word-fall-through FIFO controller in front of a two-port BRAM.
//   Writes go through BRAM port b; the head word is read through port a,
//   whose registered address is re-presented every cycle so out_data holds
//   steady under stall.
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     in_valid/in_ready/in_data    producer stream
//     out_valid/out_ready/out_data consumer stream (out_data from BRAM)
//     level                        words stored, including displayed head
//     full, empty                  level == depth, level == 0
module fifo_bram_ctrl
  import fifo_bram_ctrl_pkg::*;
#(
  parameter int DATA = DEF_DATA,
  parameter int ADDR = DEF_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic [ADDR:0]   level,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = ptr_width(ADDR);
  localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(depth_of(ADDR));
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] hptr_q, hptr_d;
  out_state_e       state_q, state_d;

  logic             push, pop, issue;
  logic [PTR_W-1:0] fptr;
  logic [ADDR-1:0]  rd_addr;
  logic [DATA-1:0]  unused_b_rdata;

  assign out_valid = (state_q == OUT_VALID);
  assign level     = wptr_q - hptr_q;
  assign full      = (level == DEPTH_LVL);
  assign empty     = (level == '0);
  // Ready depends only on registered pointers, so out_ready never reaches
  // in_ready combinationally; held low while reset is asserted.
  assign in_ready  = rst_n & ~full;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next slot to fetch: the head itself when nothing is displayed,
  // otherwise the slot behind the displayed head.
  assign fptr  = hptr_q + PTR_W'(out_valid);
  assign issue = (fptr != wptr_q) & (~out_valid | pop);

  // Without a fetch, keep addressing the displayed slot so the registered
  // read address (and out_data) stays put.
  assign rd_addr = issue ? fptr[ADDR-1:0] : hptr_q[ADDR-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wptr_d  = wptr_q;
    hptr_d  = hptr_q;
    state_d = state_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  hptr_d = hptr_q + PTR_ONE;
    case (state_q)
      OUT_EMPTY: if (issue)         state_d = OUT_VALID;
      OUT_VALID: if (pop && !issue) state_d = OUT_EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignment; the combinational
  // block above uses blocking assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      hptr_q  <= '0;
      state_q <= OUT_EMPTY;
    end else begin
      wptr_q  <= wptr_d;
      hptr_q  <= hptr_d;
      state_q <= state_d;
    end
  end

  bram_2psync_6_8_59fe624214af9b8daa183282288d5eb56b321f14 #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_bram (
    .clk     (clk),
    .a_we    (1'b0),
    .a_addr  (rd_addr),
    .a_wdata ('0),
    .a_rdata (out_data),
    .b_we    (push),
    .b_addr  (wptr_q[ADDR-1:0]),
    .b_wdata (in_data),
    .b_rdata (unused_b_rdata)
  );

endmodule
